game_controller: RTL and testbench

Top-level sequencer for the memory game. Generates a 5-digit random sequence into the 32x20 sequence RAM, starts the display block, hands control to the sequence checker, and advances the level or consumes a life from the checker's correct/incorrect pulses. It also owns the single RAM port and muxes it between its own write, the display reader and the checker reader according to game phase.

---
 rtl/game_controller.sv | 165 ++++++++++++++++
 tb/tb_game_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Top-level sequencer for the memory game: builds the 5-digit sequence word, drives the
// display and checker hand-offs, tracks level and lives, and owns the shared RAM port.
module game_controller #(
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned MAX_LVL     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  rand_digit,
    input  logic        disp_done,
    input  logic        correct,
    input  logic        incorrect,
    input  logic        disp_RAM_r,
    input  logic [4:0]  disp_RAM_addr,
    input  logic        chk_RAM_r,
    input  logic [4:0]  chk_RAM_addr,
    output logic        RAM_r,
    output logic        RAM_we,
    output logic [4:0]  RAM_addr,
    output logic [19:0] RAM_din,
    output logic        disp_start,
    output logic        chk_go,
    output logic [2:0]  LVL,
    output logic [1:0]  lives,
    output logic        game_won,
    output logic        game_lost
);

    localparam logic [1:0] LivesInit = START_LIVES[1:0];
    localparam logic [2:0] LvlMax    = MAX_LVL[2:0];
    localparam logic [2:0] GenLast   = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StWrite,
        StShow,
        StWaitd,
        StPlay,
        StWin,
        StLose
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  lvl_q, lvl_d;
    logic [1:0]  lives_q, lives_d;
    logic [2:0]  gen_cnt_q, gen_cnt_d;
    logic [19:0] seq_q, seq_d;
    logic        chk_go_q, chk_go_d;
    logic        ram_r_q, ram_r_d;
    logic [4:0]  ram_addr_q, ram_addr_d;
    logic [3:0]  digit;

    // Fold 10..15 back into 0..9 so every stored nibble is a decimal digit.
    assign digit = (rand_digit > 4'd9) ? (rand_digit - 4'd10) : rand_digit;

    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        lives_d   = lives_q;
        gen_cnt_d = gen_cnt_q;
        seq_d     = seq_q;
        chk_go_d  = 1'b0;

        case (state_q)
            StIdle, StWin, StLose: begin
                if (start) begin
                    state_d   = StGen;
                    lvl_d     = 3'd1;
                    lives_d   = LivesInit;
                    gen_cnt_d = 3'd0;
                end
            end
            StGen: begin
                seq_d     = {seq_q[15:0], digit};
                gen_cnt_d = gen_cnt_q + 3'd1;
                if (gen_cnt_q == GenLast) begin
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StShow;
            StShow:  state_d = StWaitd;
            StWaitd: begin
                if (disp_done) begin
                    state_d  = StPlay;
                    chk_go_d = 1'b1;
                end
            end
            StPlay: begin
                // incorrect wins when both pulses arrive together
                if (incorrect) begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? StLose : StShow;
                end else if (correct) begin
                    if (lvl_q == LvlMax) begin
                        state_d = StWin;
                    end else begin
                        lvl_d   = lvl_q + 3'd1;
                        state_d = StShow;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // RAM read arbitration: only the phase owner's request is forwarded, one cycle late.
    always_comb begin
        ram_r_d    = 1'b0;
        ram_addr_d = 5'd0;
        case (state_q)
            StShow, StWaitd: begin
                if (disp_RAM_r) begin
                    ram_r_d    = 1'b1;
                    ram_addr_d = disp_RAM_addr;
                end
            end
            StPlay: begin
                if (chk_RAM_r) begin
                    ram_r_d    = 1'b1;
                    ram_addr_d = chk_RAM_addr;
                end
            end
            default: begin
                ram_r_d    = 1'b0;
                ram_addr_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            lvl_q      <= 3'd1;
            lives_q    <= LivesInit;
            gen_cnt_q  <= 3'd0;
            seq_q      <= 20'd0;
            chk_go_q   <= 1'b0;
            ram_r_q    <= 1'b0;
            ram_addr_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            lives_q    <= lives_d;
            gen_cnt_q  <= gen_cnt_d;
            seq_q      <= seq_d;
            chk_go_q   <= chk_go_d;
            ram_r_q    <= ram_r_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign RAM_r      = ram_r_q;
    assign RAM_addr   = ram_addr_q;
    assign RAM_we     = (state_q == StWrite);
    assign RAM_din    = (state_q == StWrite) ? seq_q : 20'd0;
    assign disp_start = (state_q == StShow);
    assign chk_go     = chk_go_q;
    assign LVL        = lvl_q;
    assign lives      = lives_q;
    assign game_won   = (state_q == StWin);
    assign game_lost  = (state_q == StLose);

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed scenarios plus randomized games
// checked against a rule-level model of level, lives and the stored sequence word.
module tb_game_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  rand_digit = 4'd0;
    logic        disp_done = 1'b0;
    logic        correct = 1'b0;
    logic        incorrect = 1'b0;
    logic        disp_RAM_r = 1'b0;
    logic [4:0]  disp_RAM_addr = 5'd0;
    logic        chk_RAM_r = 1'b0;
    logic [4:0]  chk_RAM_addr = 5'd0;
    logic        RAM_r, RAM_we;
    logic [4:0]  RAM_addr;
    logic [19:0] RAM_din;
    logic        disp_start, chk_go;
    logic [2:0]  LVL;
    logic [1:0]  lives;
    logic        game_won, game_lost;

    int checks = 0;
    int errors = 0;
    int n_disp = 0;

    // Reference model state
    int m_lvl, m_lives, m_word;
    bit m_won, m_lost;
    logic [3:0] dir_digits [5];

    game_controller #(.START_LIVES(3), .MAX_LVL(5)) dut (
        .clk(clk), .rst(rst), .start(start), .rand_digit(rand_digit),
        .disp_done(disp_done), .correct(correct), .incorrect(incorrect),
        .disp_RAM_r(disp_RAM_r), .disp_RAM_addr(disp_RAM_addr),
        .chk_RAM_r(chk_RAM_r), .chk_RAM_addr(chk_RAM_addr),
        .RAM_r(RAM_r), .RAM_we(RAM_we), .RAM_addr(RAM_addr), .RAM_din(RAM_din),
        .disp_start(disp_start), .chk_go(chk_go), .LVL(LVL), .lives(lives),
        .game_won(game_won), .game_lost(game_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (disp_start === 1'b1) n_disp <= n_disp + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".lvl"}, 32'(LVL), 32'(m_lvl));
        check({tag, ".lives"}, 32'(lives), 32'(m_lives));
        check({tag, ".won"}, 32'(game_won), 32'(m_won));
        check({tag, ".lost"}, 32'(game_lost), 32'(m_lost));
    endtask

    // From IDLE/WIN/LOSE: pulse start, feed 5 digits, check the write and display start.
    task automatic start_game(input bit directed);
        logic [3:0] r;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_lvl = 1; m_lives = 3; m_won = 0; m_lost = 0; m_word = 0;
        check_status("start");
        for (int i = 0; i < 5; i++) begin
            r = directed ? dir_digits[i] : 4'($urandom_range(0, 15));
            rand_digit = r;
            m_word = m_word * 16 + (int'(r) % 10);
            if (i == 2) start = 1'b1;  // ignored during GEN
            tick();
            start = 1'b0;
            check("gen.no_we", 32'(RAM_we), 32'(i == 4));
        end
        check("write.addr", 32'(RAM_addr), 32'd0);
        check("write.din", 32'(RAM_din), 32'(m_word));
        check("write.disp_start", 32'(disp_start), 32'd0);
        tick();
        check("show.disp_start", 32'(disp_start), 32'd1);
        check("show.we", 32'(RAM_we), 32'd0);
        tick();
        check("waitd.disp_start", 32'(disp_start), 32'd0);
    endtask

    // From WAITD: distractors, RAM arbitration, disp_done, then a checker read in PLAY.
    task automatic enter_play();
        logic [4:0] a;
        correct = 1'b1;
        chk_RAM_r = 1'b1; chk_RAM_addr = 5'd0;
        tick();
        correct = 1'b0; chk_RAM_r = 1'b0;
        check("waitd.chk_dropped", 32'(RAM_r), 32'd0);
        check_status("waitd.correct_ignored");
        a = 5'($urandom_range(1, 31));
        disp_RAM_r = 1'b1; disp_RAM_addr = a;
        tick();
        disp_RAM_r = 1'b0;
        check("waitd.disp_r", 32'(RAM_r), 32'd1);
        check("waitd.disp_addr", 32'(RAM_addr), 32'(a));
        check("waitd.no_chk_go", 32'(chk_go), 32'd0);
        disp_done = 1'b1;
        tick();
        disp_done = 1'b0;
        check("play.chk_go", 32'(chk_go), 32'd1);
        a = 5'($urandom_range(1, 31));
        chk_RAM_r = 1'b1; chk_RAM_addr = a;
        disp_RAM_r = 1'b1; disp_RAM_addr = 5'd0;
        start = 1'b1;  // ignored during PLAY
        tick();
        chk_RAM_r = 1'b0; disp_RAM_r = 1'b0; start = 1'b0;
        check("play.chk_go_once", 32'(chk_go), 32'd0);
        check("play.chk_r", 32'(RAM_r), 32'd1);
        check("play.chk_addr", 32'(RAM_addr), 32'(a));
        check_status("play.start_ignored");
    endtask

    // From PLAY: apply a checker result and compare against the model.
    task automatic resolve(input bit c, input bit i);
        correct = c; incorrect = i;
        tick();
        correct = 1'b0; incorrect = 1'b0;
        if (i) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) m_lost = 1;
        end else if (c) begin
            if (m_lvl == 5) m_won = 1;
            else m_lvl = m_lvl + 1;
        end
        check_status("result");
        check("result.disp_start", 32'(disp_start), 32'(!(m_won || m_lost)));
        if (!(m_won || m_lost)) begin
            tick();
            check("replay.no_we", 32'(RAM_we), 32'd0);
            check("replay.disp_start_off", 32'(disp_start), 32'd0);
        end
    endtask

    initial begin
        int n0, k;
        dir_digits[0] = 4'd2; dir_digits[1] = 4'd7; dir_digits[2] = 4'd12;
        dir_digits[3] = 4'd0; dir_digits[4] = 4'd9;
        m_lvl = 1; m_lives = 3; m_won = 0; m_lost = 0; m_word = 0;

        #12 rst = 1'b1;
        tick();
        check_status("reset");
        check("reset.we", 32'(RAM_we), 32'd0);
        check("reset.disp_start", 32'(disp_start), 32'd0);
        check("reset.chk_go", 32'(chk_go), 32'd0);
        check("reset.ram_r", 32'(RAM_r), 32'd0);

        // Directed sequence 2,7,12,0,9 -> 27209, then win through all five levels.
        n0 = n_disp;
        start_game(1'b1);
        check("directed.word", 32'(m_word), 32'h27209);
        for (int l = 0; l < 5; l++) begin
            enter_play();
            resolve(1'b1, 1'b0);
        end
        check("win.flag", 32'(game_won), 32'd1);
        check("win.disp_pulses", 32'(n_disp - n0), 32'd5);
        tick();
        check("win.holds", 32'(game_won), 32'd1);

        // Three misses at level 2, with a simultaneous correct/incorrect first.
        start_game(1'b0);
        enter_play();
        resolve(1'b1, 1'b0);
        enter_play();
        resolve(1'b1, 1'b1);
        enter_play();
        resolve(1'b0, 1'b1);
        enter_play();
        resolve(1'b0, 1'b1);
        check("lose.flag", 32'(game_lost), 32'd1);
        check("lose.lvl", 32'(LVL), 32'd2);
        tick();
        check("lose.holds", 32'(game_lost), 32'd1);

        // Asynchronous reset in the middle of PLAY at level 3.
        start_game(1'b0);
        enter_play(); resolve(1'b1, 1'b0);
        enter_play(); resolve(1'b1, 1'b0);
        enter_play();
        check("pre_reset.lvl", 32'(LVL), 32'd3);
        #2 rst = 1'b0;
        #1;
        m_lvl = 1; m_lives = 3; m_won = 0; m_lost = 0;
        check_status("async_reset");
        check("async_reset.we", 32'(RAM_we), 32'd0);
        check("async_reset.ram_r", 32'(RAM_r), 32'd0);
        check("async_reset.chk_go", 32'(chk_go), 32'd0);
        rst = 1'b1;
        tick();
        check_status("post_reset");
        check("post_reset.disp_start", 32'(disp_start), 32'd0);

        // Randomized games.
        for (int g = 0; g < 6; g++) begin
            start_game(1'b0);
            for (int s = 0; s < 20 && !(m_won || m_lost); s++) begin
                enter_play();
                k = $urandom_range(0, 3);
                resolve(k != 2, k >= 2);
            end
            check("rand.terminal", 32'(m_won || m_lost), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
